// File: rtl/alu_operand_loader.sv
// alu_operand_loader
// Front end for the ALU. Two active-low pushbuttons are synchronised and
// debounced. Load presses step the user through capturing operand A, operand
// B and the opcode. A clear press returns to the start. The stage presents
// registered a/b/op to the ALU, and valid qualifies a complete set.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   sw      operand switches, sampled only on a load capture edge
//   op_sw   opcode switches, sampled only on the opcode capture edge
//   load_n  load button, low = pressed
//   clr_n   clear button, low = pressed
//   a, b    registered operands to the ALU
//   op      registered opcode to the ALU
//   valid   high while a/b/op form a complete set (READY)
//   stage   current state encoding
//
// state   | meaning
// --------+---------------------------------------------------
// LOAD_A  | waiting for the load press that captures sw into a
// LOAD_B  | waiting for the load press that captures sw into b
// LOAD_OP | waiting for the load press that captures op_sw into op
// READY   | a/b/op complete, valid high; next load press restarts
module alu_operand_loader #(
  parameter int N               = 4,
  parameter int OPW             = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sw,
  input  logic [OPW-1:0] op_sw,
  input  logic           load_n,
  input  logic           clr_n,
  output logic [N-1:0]   a,
  output logic [N-1:0]   b,
  output logic [OPW-1:0] op,
  output logic           valid,
  output logic [1:0]     stage
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t state;

  // Index 0 = load, index 1 = clear.
  logic [1:0] btn_n;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] press;

  assign btn_n = {clr_n, load_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1[gi] <= 1'b1;
        sync2[gi] <= 1'b1;
        deb[gi]   <= 1'b1;
        cnt       <= '0;
      end else begin
        sync1[gi] <= btn_n[gi];
        sync2[gi] <= sync1[gi];
        if (sync2[gi] == deb[gi]) begin
          cnt <= '0;
        end else if (cnt == TC) begin
          deb[gi] <= sync2[gi];
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // The press event is true only in the cycle before deb falls. A held
    // button therefore yields one event, and the release must debounce
    // before another press event can occur.
    assign press[gi] = ~sync2[gi] & deb[gi] & (cnt == TC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
    end else if (press[1]) begin
      // A clear press overrides a load press on the same edge.
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
    end else if (press[0]) begin
      case (state)
        LOAD_A: begin
          a     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: begin
          op    <= op_sw;
          valid <= 1'b1;
          state <= READY;
        end
        READY: begin
          // The old operands stay visible while the user reloads.
          valid <= 1'b0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign stage = state;

endmodule
